// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: state encoding,
// frame width, baud divider computation and a 2-of-3 vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Rounded clocks-per-oversample-tick.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        int d;
        d = baud * os;
        return (clk_hz + d / 2) / d;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Next-state and strobe decode for the UART receiver; the state register
// and all counters live in uart_rx.
module uart_rx_fsm
    import uart_pkg::*;
(
    input  rx_state_t state,
    input  logic      rx_s,
    input  logic      bit_evt,
    input  logic      bit_val,
    input  logic      last_bit,
    output rx_state_t state_next,
    output logic      start_clr,
    output logic      shift_en,
    output logic      valid_set,
    output logic      ferr_set
);

    always_comb begin
        state_next = state;
        start_clr  = 1'b0;
        shift_en   = 1'b0;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    start_clr  = 1'b1;
                end
            end
            START: begin
                if (bit_evt) begin
                    state_next = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_evt) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (bit_evt) begin
                    if (bit_val) begin
                        valid_set  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_MAJORITY_EN to vote each bit over three adjacent oversamples.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      framing_error,
    output logic                      busy
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int SP    = OVERSAMPLE / 2;
    localparam int BC_W  = $clog2(UART_DATA_BITS);

    logic [1:0]                sync_reg;
    logic                      rx_s;
    logic [DIV_W-1:0]          div_cnt_reg;
    logic                      os_tick;
    logic [OS_W-1:0]           os_cnt_reg;
    logic [BC_W-1:0]           bit_cnt_reg;
    logic [UART_DATA_BITS-1:0] shreg_reg;
    logic [UART_DATA_BITS-1:0] data_reg;
    logic                      valid_reg;
    logic                      ferr_reg;
    rx_state_t                 state_reg;
    rx_state_t                 state_next;
    logic                      bit_evt;
    logic                      bit_val;
    logic                      last_bit;
    logic                      start_clr;
    logic                      shift_en;
    logic                      valid_set;
    logic                      ferr_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end
    assign rx_s = sync_reg[1];

    assign os_tick = (div_cnt_reg == DIV_W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || start_clr) begin
            div_cnt_reg <= '0;
            os_cnt_reg  <= '0;
        end else if (os_tick) begin
            div_cnt_reg <= '0;
            os_cnt_reg  <= os_cnt_reg + OS_W'(1);
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // os_cnt wraps freely, so each later arrival at SP is exactly one bit
    // period after the previous one and stays centred in the bit.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_reg <= 2'b11;
        end else if (os_tick) begin
            hist_reg <= {hist_reg[0], rx_s};
        end
    end

    // Decision on the tick reaching SP+1, voting samples at SP-1, SP, SP+1.
    assign bit_evt = os_tick && (os_cnt_reg == OS_W'(SP));
    assign bit_val = majority3(hist_reg[1], hist_reg[0], rx_s);
`else
    assign bit_evt = os_tick && (os_cnt_reg == OS_W'(SP - 1));
    assign bit_val = rx_s;
`endif

    assign last_bit = (bit_cnt_reg == BC_W'(UART_DATA_BITS - 1));

    uart_rx_fsm u_fsm (
        .state      (state_reg),
        .rx_s       (rx_s),
        .bit_evt    (bit_evt),
        .bit_val    (bit_val),
        .last_bit   (last_bit),
        .state_next (state_next),
        .start_clr  (start_clr),
        .shift_en   (shift_en),
        .valid_set  (valid_set),
        .ferr_set   (ferr_set)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_set;
            ferr_reg  <= ferr_set;
            if (shift_en) begin
                shreg_reg   <= {bit_val, shreg_reg[UART_DATA_BITS-1:1]};
                bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
            end else if (state_reg != DATA) begin
                bit_cnt_reg <= '0;
            end
            if (valid_set) begin
                data_reg <= shreg_reg;
            end
        end
    end

    assign data          = data_reg;
    assign valid         = valid_reg;
    assign framing_error = ferr_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 1.6 MHz / 10 kbaud (160 clocks per bit).
// Build with UART_RX_MAJORITY_EN to also require the glitch-filtered byte.
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         dc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    uart_rx #(
        .CLK_HZ     (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic hold(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int glitch_bit);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(b[i], 75);
                hold(~b[i], 10);
                hold(b[i], 75);
            end else begin
                hold(b[i], BIT_CLKS);
            end
        end
        hold(stop_lvl, BIT_CLKS);
    endtask

    task automatic expect_byte(input logic [7:0] b, input bit dc);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = b;
        e.dc     = dc;
        q.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] held);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = held;
        e.dc     = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard queue.
    always @(negedge clock) begin
        if (!reset && (valid || framing_error)) begin
            exp_t e;
            total++;
            if (valid && framing_error) begin
                bad++;
                $display("FAIL strobe_overlap: valid=%b framing_error=%b both high", valid, framing_error);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: valid=%b framing_error=%b data=%h, none expected",
                         valid, framing_error, data);
            end else begin
                e = q.pop_front();
                if (e.is_err != framing_error) begin
                    bad++;
                    $display("FAIL strobe_kind: framing_error=%b expected %b", framing_error, e.is_err);
                end else if (!e.dc && data !== e.data) begin
                    bad++;
                    $display("FAIL %s_data: got %h expected %h", e.is_err ? "err" : "rx", data, e.data);
                end else begin
                    $display("ok   %s strobe data=%h", e.is_err ? "err" : "rx", data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_data", data, 8'h00);
        check("reset_valid", {7'b0, valid}, 8'h00);
        check("reset_ferr", {7'b0, framing_error}, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        hold(1'b1, 50);

        // 1: single byte
        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, -1);
        hold(1'b1, 20);
        check("t1_busy_after", {7'b0, busy}, 8'h00);

        // 2: back-to-back frames
        expect_byte(8'h00, 1'b0);
        expect_byte(8'hFF, 1'b0);
        expect_byte(8'h5A, 1'b0);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h5A, 1'b1, -1);
        hold(1'b1, 100);

        // 3: stop bit low, line held low, then released
        expect_err(8'h5A);
        send_frame(8'h3C, 1'b0, -1);
        hold(1'b0, 200);
        check("t3_busy_in_break", {7'b0, busy}, 8'h01);
        check("t3_data_held", data, 8'h5A);
        hold(1'b1, 10);
        check("t3_busy_released", {7'b0, busy}, 8'h00);
        hold(1'b1, 100);

        // 4: short low pulse on idle line
        hold(1'b0, 10);
        check("t4_busy_started", {7'b0, busy}, 8'h01);
        hold(1'b0, 30);
        hold(1'b1, 90);
        check("t4_busy_cleared", {7'b0, busy}, 8'h00);
        hold(1'b1, 100);

        // 5: reset during 4th data bit of 8'hC3
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b0, BIT_CLKS);
        hold(1'b0, 60);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t5_data_cleared", data, 8'h00);
        check("t5_busy_cleared", {7'b0, busy}, 8'h00);
        hold(1'b1, 300);
        expect_byte(8'h81, 1'b0);
        send_frame(8'h81, 1'b1, -1);
        hold(1'b1, 100);

        // 6: high glitch in the middle of a zero data bit
`ifdef UART_RX_MAJORITY_EN
        expect_byte(8'h00, 1'b0);
`else
        expect_byte(8'h00, 1'b1);
`endif
        send_frame(8'h00, 1'b1, 2);
        hold(1'b1, 300);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d strobes outstanding, expected 0", q.size());
        end else begin
            $display("ok   scoreboard drained");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
